lsu_dmem_if: RTL and testbench
==============================

// Module: lsu_dmem_if
// PURPOSE
//  Memory-stage load/store unit between the X-stage ALU outputs and the data memory.
//  Per memory op it aligns the address, builds byte enables and replicated store data,
//  and runs a req/gnt/rvalid handshake with the data memory, stalling the pipeline meanwhile.
//  Returns the raw 32-bit load word (m_dm_dout_o) for W-stage byte/half extraction and sign/zero extension.
// PARAMETERS
//  TIMEOUT   64   max cycles spent in one handshake state (REQ or RESP) before aborting with bus_err_o
// PORTS
//  clk_i             in   1   clock, rising edge
//  rst_n_i           in   1   asynchronous active-low reset
//  x_mem_req_i       in   1   X stage holds a load/store this cycle
//  x_mem_we_i        in   1   1=store, 0=load
//  x_funct3_i        in   3   LB/SB=000 LH/SH=001 LW/SW=010 LBU=100 LHU=101
//  x_addr_i          in   32  byte address (arith result)
//  x_store_data_i    in   32  store operand (rs2 value)
//  dm_req_o          out  1   memory request, held until dm_gnt_i
//  dm_we_o           out  1   write enable, stable while dm_req_o
//  dm_addr_o         out  32  word address, {x_addr_i[31:2],2'b00}
//  dm_be_o           out  4   byte enables
//  dm_wdata_o        out  32  lane-replicated store data
//  dm_gnt_i          in   1   memory accepted request
//  dm_rvalid_i       in   1   read data valid (loads only)
//  dm_rdata_i        in   32  read data word
//  m_dm_dout_o       out  32  last load word, registered
//  stall_o           out  1   freeze pipeline (combinational)
//  misaligned_o      out  1   1-cycle pulse: misaligned/illegal access dropped
//  bus_err_o         out  1   1-cycle pulse: handshake timed out
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; timeout counter 0. Reset mid-transaction aborts it with no pulse.
//  FSM IDLE -> REQ -> (store: IDLE | load: RESP -> IDLE).
//  IDLE: accept = x_mem_req_i & legal. On accept, register addr/be/wdata/we; next state REQ.
//   Not legal: funct3 in {011,110,111}; stores with funct3[2]=1; H with addr[0]=1; W with addr[1:0]!=0.
//   Illegal req: no bus request; misaligned_o=1 the next cycle; stall_o stays 0.
//  REQ: dm_req_o=1. On dm_gnt_i: store -> IDLE, load -> RESP. Request fields must not change before gnt.
//  RESP: dm_req_o=0. On dm_rvalid_i: m_dm_dout_o<=dm_rdata_i; -> IDLE. rvalid outside RESP is ignored.
//  Byte enables (loads and stores): B: 4'b0001<<addr[1:0]; H: addr[1]?4'b1100:4'b0011; W: 4'b1111.
//  wdata: B -> {4{d[7:0]}}; H -> {2{d[15:0]}}; W -> d.
//  stall_o = accept | (REQ & ~(dm_gnt_i & we)) | (RESP & ~dm_rvalid_i).
//   Drops in the completion cycle so the pipeline advances on that edge. No op is issued twice.
//  x_mem_req_i is sampled only in IDLE.
//  Timeout: counter clears on each state entry and increments each cycle in REQ/RESP.
//   At TIMEOUT-1 without progress: bus_err_o=1 next cycle; m_dm_dout_o<=0; -> IDLE.
//   stall_o drops in that cycle.
//  m_dm_dout_o holds its value until the next load completes or a load times out.
//  Latency, zero-wait memory: store stall 1 cycle; load stall 2 cycles; data valid the edge after rvalid.
// TESTING
//  SW addr 0x100, data 0xDEADBEEF, gnt at once -> dm_req 1 cycle, be=1111, addr 0x100, stall 1 cycle.
//  SB addr 0x103, data 0x000000A5 -> be=1000, wdata=0xA5A5A5A5; SH addr 0x102 -> be=1100.
//  LW addr 0x40, gnt 3 cycles late, rvalid 2 later with 0x12345678 -> stall 6 cycles, m_dm_dout_o=0x12345678.
//  LH addr 0x41 / LW addr 0x42 / funct3=011 -> no dm_req_o, misaligned_o pulse, stall_o 0.
//  LW with gnt never given, TIMEOUT=64 -> bus_err_o pulse after 64 REQ cycles, then IDLE; m_dm_dout_o=0.
//  rst_n_i low while in RESP -> outputs 0 at once; after release, next LW completes normally.

Source files
------------

// File: rtl/lsu_dmem_if.sv
// Memory-stage load/store unit: aligns the access, builds byte enables and lane-replicated
// store data, and runs the req/gnt/rvalid handshake with the data memory.
module lsu_dmem_if #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        x_mem_req_i,
  input  logic        x_mem_we_i,
  input  logic [2:0]  x_funct3_i,
  input  logic [31:0] x_addr_i,
  input  logic [31:0] x_store_data_i,
  output logic        dm_req_o,
  output logic        dm_we_o,
  output logic [31:0] dm_addr_o,
  output logic [3:0]  dm_be_o,
  output logic [31:0] dm_wdata_o,
  input  logic        dm_gnt_i,
  input  logic        dm_rvalid_i,
  input  logic [31:0] dm_rdata_i,
  output logic [31:0] m_dm_dout_o,
  output logic        stall_o,
  output logic        misaligned_o,
  output logic        bus_err_o
);

  localparam int unsigned CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          we_q, we_d;
  logic [31:0]   dout_q, dout_d;
  logic          mis_q, mis_d;
  logic          berr_q, berr_d;

  logic          legal;
  logic [3:0]    be_n;
  logic [31:0]   wdata_n;
  logic          accept;
  logic          timeout;

  // Decode legality, byte enables and replicated store data from the X-stage op.
  always_comb begin
    legal   = 1'b1;
    be_n    = 4'b0000;
    wdata_n = x_store_data_i;
    case (x_funct3_i)
      3'b000, 3'b100: begin
        be_n    = 4'b0001 << x_addr_i[1:0];
        wdata_n = {4{x_store_data_i[7:0]}};
      end
      3'b001, 3'b101: begin
        be_n    = x_addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_n = {2{x_store_data_i[15:0]}};
        legal   = ~x_addr_i[0];
      end
      3'b010: begin
        be_n  = 4'b1111;
        legal = (x_addr_i[1:0] == 2'b00);
      end
      default: legal = 1'b0;
    endcase
    if (x_mem_we_i && x_funct3_i[2]) legal = 1'b0;
  end

  assign accept  = (state_q == IDLE) & x_mem_req_i & legal;
  assign timeout = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    dout_d  = dout_q;
    mis_d   = 1'b0;
    berr_d  = 1'b0;
    stall_o = 1'b0;
    case (state_q)
      IDLE: begin
        mis_d = x_mem_req_i & ~legal;
        if (accept) begin
          state_d = REQ;
          addr_d  = {x_addr_i[31:2], 2'b00};
          be_d    = be_n;
          wdata_d = wdata_n;
          we_d    = x_mem_we_i;
          stall_o = 1'b1;
        end
      end
      REQ: begin
        if (dm_gnt_i) begin
          state_d = we_q ? IDLE : RESP;
          stall_o = ~we_q;
        end else if (timeout) begin
          state_d = IDLE;
          berr_d  = 1'b1;
          if (!we_q) dout_d = '0;
        end else begin
          stall_o = 1'b1;
        end
      end
      RESP: begin
        if (dm_rvalid_i) begin
          state_d = IDLE;
          dout_d  = dm_rdata_i;
        end else if (timeout) begin
          state_d = IDLE;
          berr_d  = 1'b1;
          dout_d  = '0;
        end else begin
          stall_o = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Counter restarts on every state entry so REQ and RESP each get a full budget.
    if (state_d != state_q || state_q == IDLE) cnt_d = '0;
    else                                         cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      dout_q  <= '0;
      mis_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      dout_q  <= dout_d;
      mis_q   <= mis_d;
      berr_q  <= berr_d;
    end
  end

  assign dm_req_o     = (state_q == REQ);
  assign dm_we_o      = we_q;
  assign dm_addr_o    = addr_q;
  assign dm_be_o      = be_q;
  assign dm_wdata_o   = wdata_q;
  assign m_dm_dout_o  = dout_q;
  assign misaligned_o = mis_q;
  assign bus_err_o    = berr_q;

endmodule

// File: tb/tb_lsu_dmem_if.sv
// Directed bench for lsu_dmem_if: a small memory responder with programmable gnt/rvalid delays.
module tb_lsu_dmem_if;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        x_mem_req_i;
  logic        x_mem_we_i;
  logic [2:0]  x_funct3_i;
  logic [31:0] x_addr_i;
  logic [31:0] x_store_data_i;
  logic        dm_req_o;
  logic        dm_we_o;
  logic [31:0] dm_addr_o;
  logic [3:0]  dm_be_o;
  logic [31:0] dm_wdata_o;
  logic        dm_gnt_i;
  logic        dm_rvalid_i;
  logic [31:0] dm_rdata_i;
  logic [31:0] m_dm_dout_o;
  logic        stall_o;
  logic        misaligned_o;
  logic        bus_err_o;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [31:0] cap_addr, cap_wdata, post_dout;
  logic [3:0]  cap_be;
  logic        cap_we, post_mis, post_berr, post_req;
  int          stab_err;
  int          nstall, nreq;

  lsu_dmem_if #(.TIMEOUT(64)) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .x_mem_req_i    (x_mem_req_i),
    .x_mem_we_i     (x_mem_we_i),
    .x_funct3_i     (x_funct3_i),
    .x_addr_i       (x_addr_i),
    .x_store_data_i (x_store_data_i),
    .dm_req_o       (dm_req_o),
    .dm_we_o        (dm_we_o),
    .dm_addr_o      (dm_addr_o),
    .dm_be_o        (dm_be_o),
    .dm_wdata_o     (dm_wdata_o),
    .dm_gnt_i       (dm_gnt_i),
    .dm_rvalid_i    (dm_rvalid_i),
    .dm_rdata_i     (dm_rdata_i),
    .m_dm_dout_o    (m_dm_dout_o),
    .stall_o        (stall_o),
    .misaligned_o   (misaligned_o),
    .bus_err_o      (bus_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  // Issue one op and hold it until stall_o drops; the responder grants after gdel
  // request cycles and returns rvalid rdel cycles after the grant.
  task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] data, input int gdel, input int rdel,
                        input logic [31:0] rdata);
    int  reqcyc, sg;
    bit  granted, done;
    nstall = 0; nreq = 0; stab_err = 0;
    reqcyc = 0; sg = 0; granted = 0; done = 0;
    cyc();
    x_mem_req_i = 1'b1; x_mem_we_i = we; x_funct3_i = f3;
    x_addr_i = addr; x_store_data_i = data; dm_rdata_i = rdata;
    for (int k = 0; k < 200 && !done; k++) begin
      if (k != 0) cyc();
      if (granted) sg++;
      dm_gnt_i    = dm_req_o && (reqcyc == gdel);
      dm_rvalid_i = granted && !cap_we && (sg == rdel);
      #1;
      if (dm_req_o) begin
        if (reqcyc == 0) begin
          cap_addr = dm_addr_o; cap_be = dm_be_o; cap_wdata = dm_wdata_o; cap_we = dm_we_o;
        end else if (dm_addr_o !== cap_addr || dm_be_o !== cap_be ||
                     dm_wdata_o !== cap_wdata || dm_we_o !== cap_we) begin
          stab_err++;
        end
        reqcyc++;
        nreq++;
      end
      if (dm_gnt_i) granted = 1;
      if (stall_o) nstall++;
      else done = 1;
    end
    if (!done) check("cycle_budget", 32'd0, 32'd1);
    cyc();
    x_mem_req_i = 1'b0; dm_gnt_i = 1'b0; dm_rvalid_i = 1'b0;
    #1;
    post_mis = misaligned_o; post_berr = bus_err_o;
    post_dout = m_dm_dout_o; post_req = dm_req_o;
  endtask

  initial begin
    rst_n_i = 1'b0; x_mem_req_i = 1'b0; x_mem_we_i = 1'b0; x_funct3_i = 3'b000;
    x_addr_i = '0; x_store_data_i = '0; dm_gnt_i = 1'b0; dm_rvalid_i = 1'b0; dm_rdata_i = '0;
    cap_we = 1'b0;
    #12;
    check("rst_req", {31'd0, dm_req_o}, 32'd0);
    check("rst_stall", {31'd0, stall_o}, 32'd0);
    check("rst_addr", dm_addr_o, 32'd0);
    check("rst_dout", m_dm_dout_o, 32'd0);
    check("rst_flags", {30'd0, misaligned_o, bus_err_o}, 32'd0);
    rst_n_i = 1'b1;

    run_op(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 0, 0, '0);
    check("sw_req", nreq, 1);
    check("sw_stall", nstall, 1);
    check("sw_be", {28'd0, cap_be}, 32'h0000_000F);
    check("sw_addr", cap_addr, 32'h0000_0100);
    check("sw_wdata", cap_wdata, 32'hDEAD_BEEF);
    check("sw_we", {31'd0, cap_we}, 32'd1);

    run_op(1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 0, 0, '0);
    check("sb_be", {28'd0, cap_be}, 32'h0000_0008);
    check("sb_wdata", cap_wdata, 32'hA5A5_A5A5);
    check("sb_addr", cap_addr, 32'h0000_0100);

    run_op(1'b1, 3'b001, 32'h0000_0102, 32'h1234_BEEF, 0, 0, '0);
    check("sh_be", {28'd0, cap_be}, 32'h0000_000C);
    check("sh_wdata", cap_wdata, 32'hBEEF_BEEF);

    run_op(1'b0, 3'b010, 32'h0000_0040, '0, 3, 2, 32'h1234_5678);
    check("lw_stall", nstall, 6);
    check("lw_req", nreq, 4);
    check("lw_stable", stab_err, 0);
    check("lw_addr", cap_addr, 32'h0000_0040);
    check("lw_we", {31'd0, cap_we}, 32'd0);
    check("lw_dout", post_dout, 32'h1234_5678);
    check("lw_no_berr", {31'd0, post_berr}, 32'd0);

    run_op(1'b0, 3'b100, 32'h0000_0042, '0, 0, 1, 32'hAABB_CCDD);
    check("lbu_stall", nstall, 2);
    check("lbu_be", {28'd0, cap_be}, 32'h0000_0004);
    check("lbu_dout", post_dout, 32'hAABB_CCDD);

    run_op(1'b0, 3'b001, 32'h0000_0041, '0, 0, 1, 32'h0);
    check("lh_odd_req", nreq, 0);
    check("lh_odd_stall", nstall, 0);
    check("lh_odd_mis", {31'd0, post_mis}, 32'd1);
    check("lh_odd_keep", post_dout, 32'hAABB_CCDD);

    run_op(1'b0, 3'b010, 32'h0000_0042, '0, 0, 1, 32'h0);
    check("lw_mis_req", nreq, 0);
    check("lw_mis_mis", {31'd0, post_mis}, 32'd1);

    run_op(1'b0, 3'b011, 32'h0000_0040, '0, 0, 1, 32'h0);
    check("f011_req", nreq, 0);
    check("f011_stall", nstall, 0);
    check("f011_mis", {31'd0, post_mis}, 32'd1);
    cyc();
    check("mis_pulse_end", {31'd0, misaligned_o}, 32'd0);

    run_op(1'b0, 3'b010, 32'h0000_0080, '0, 100000, 1, 32'h0);
    check("to_req", nreq, 64);
    check("to_stall", nstall, 64);
    check("to_berr", {31'd0, post_berr}, 32'd1);
    check("to_dout", post_dout, 32'd0);
    check("to_idle", {31'd0, post_req}, 32'd0);
    cyc();
    check("berr_pulse_end", {31'd0, bus_err_o}, 32'd0);

    run_op(1'b0, 3'b010, 32'h0000_0010, '0, 0, 1, 32'hCAFE_F00D);
    check("lw2_dout", post_dout, 32'hCAFE_F00D);

    // Reset while waiting in RESP.
    cyc();
    x_mem_req_i = 1'b1; x_mem_we_i = 1'b0; x_funct3_i = 3'b010; x_addr_i = 32'h20;
    cyc();
    dm_gnt_i = dm_req_o;
    cyc();
    dm_gnt_i = 1'b0;
    #1;
    check("resp_stall", {31'd0, stall_o}, 32'd1);
    rst_n_i = 1'b0; x_mem_req_i = 1'b0;
    #1;
    check("rst_mid_stall", {31'd0, stall_o}, 32'd0);
    check("rst_mid_dout", m_dm_dout_o, 32'd0);
    check("rst_mid_req", {31'd0, dm_req_o}, 32'd0);
    cyc();
    check("rst_mid_flags", {30'd0, misaligned_o, bus_err_o}, 32'd0);
    rst_n_i = 1'b1;

    run_op(1'b0, 3'b010, 32'h0000_0024, '0, 0, 1, 32'h55AA_33CC);
    check("post_rst_stall", nstall, 2);
    check("post_rst_dout", post_dout, 32'h55AA_33CC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
